// File: rtl/ecc_pkg.sv
// Shared ECC controller types: field width, infinity encoding,
// affine point bundle and the scalar-multiply sequencer states.
package ecc_pkg;

  localparam int WIDTH = 256;
  localparam int CW    = $clog2(WIDTH) + 1;

  localparam logic [WIDTH-1:0] INF_COORD = {WIDTH{1'b1}};

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } point_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_DBL,
    ST_DBL_W,
    ST_ADD,
    ST_ADD_W,
    ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/scalar_mul_ctrl.sv
// Left-to-right double-and-add-always sequencer for Q = k*P.
// Drives external doubler / adder units through start/finish pulses.
module scalar_mul_ctrl
  import ecc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_busy,
  output logic             o_dbl_start,
  output logic [WIDTH-1:0] o_dbl_x,
  output logic [WIDTH-1:0] o_dbl_y,
  input  logic             i_dbl_finish,
  input  logic [WIDTH-1:0] i_dbl_x,
  input  logic [WIDTH-1:0] i_dbl_y,
  output logic             o_add_start,
  output logic [WIDTH-1:0] o_add_x1,
  output logic [WIDTH-1:0] o_add_y1,
  output logic [WIDTH-1:0] o_add_x2,
  output logic [WIDTH-1:0] o_add_y2,
  output logic             o_add_flag,
  input  logic             i_add_finish,
  input  logic [WIDTH-1:0] i_add_x,
  input  logic [WIDTH-1:0] i_add_y,
  output logic             o_finish,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y
);

  ctrl_state_e state, state_nxt;

  logic [WIDTH-1:0] ks;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_dec;
  logic             last;
  point_t           r;
  point_t           res;

  assign cnt_dec = cnt - 1'b1;
  assign last    = (cnt_dec == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (last)                state_nxt = ST_DONE;
        else if (ks[WIDTH-1])    state_nxt = ST_DBL;
      end
      ST_DBL:   state_nxt = ST_DBL_W;
      ST_DBL_W: if (i_dbl_finish) state_nxt = ST_ADD;
      ST_ADD:   state_nxt = ST_ADD_W;
      ST_ADD_W: begin
        if (i_add_finish) state_nxt = last ? ST_DONE : ST_DBL;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Scalar shift reg, bit counter and running point R.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ks  <= '0;
      cnt <= '0;
      r   <= '0;
      res <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            ks  <= i_k;
            cnt <= CW'(WIDTH);
          end
        end
        ST_SCAN: begin
          ks  <= {ks[WIDTH-2:0], 1'b0};
          cnt <= cnt_dec;
          if (ks[WIDTH-1]) begin
            r.x <= i_x;
            r.y <= i_y;
          end else if (last) begin
            r.x <= INF_COORD;
            r.y <= INF_COORD;
          end
        end
        ST_DBL_W: begin
          if (i_dbl_finish) begin
            r.x <= i_dbl_x;
            r.y <= i_dbl_y;
          end
        end
        ST_ADD_W: begin
          if (i_add_finish) begin
            r.x <= i_add_x;
            r.y <= i_add_y;
            ks  <= {ks[WIDTH-2:0], 1'b0};
            cnt <= cnt_dec;
          end
        end
        ST_DONE: res <= r;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy      = (state != ST_IDLE);
    o_dbl_start = 1'b0;
    o_dbl_x     = '0;
    o_dbl_y     = '0;
    o_add_start = 1'b0;
    o_add_x1    = '0;
    o_add_y1    = '0;
    o_add_x2    = '0;
    o_add_y2    = '0;
    o_add_flag  = 1'b0;
    o_finish    = 1'b0;
    o_result_x  = res.x;
    o_result_y  = res.y;
    unique case (state)
      ST_DBL, ST_DBL_W: begin
        o_dbl_start = (state == ST_DBL);
        o_dbl_x     = r.x;
        o_dbl_y     = r.y;
      end
      ST_ADD, ST_ADD_W: begin
        o_add_start = (state == ST_ADD);
        o_add_x1    = r.x;
        o_add_y1    = r.y;
        o_add_x2    = i_x;
        o_add_y2    = i_y;
        o_add_flag  = ks[WIDTH-1];
      end
      ST_DONE: begin
        o_finish   = 1'b1;
        o_result_x = r.x;
        o_result_y = r.y;
      end
      default: ;
    endcase
  end

endmodule
